alu_issue_queue: RTL
====================

Name: alu_issue_queue

Overview:
- Sequential front end for the combinational `alu_4bit`.
- Accepts operand/opcode requests over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents the FIFO head to `alu_4bit` and registers its result, carry and a derived zero flag into an output stage with its own valid/ready handshake.
- Sits between the request source and the ALU, and also consumes the ALU's outputs; converts the bare ALU into a flow-controlled pipeline stage.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, at least 2.
- PTR_W, 2, read/write pointer width; equals log2(DEPTH).
- CNT_W, 3, occupancy counter width; equals PTR_W+1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  request present.
- in_ready  output  1  queue can accept a request; equals !full.
- in_a  input  4  operand a.
- in_b  input  4  operand b.
- in_sel  input  2  ALU opcode.
- alu_a  output  4  to `alu_4bit` a; FIFO head a, 0 when empty.
- alu_b  output  4  to `alu_4bit` b; FIFO head b, 0 when empty.
- alu_sel  output  2  to `alu_4bit` sel; FIFO head sel, 0 when empty.
- alu_result  input  4  from `alu_4bit` result.
- alu_carry  input  1  from `alu_4bit` carry.
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  4  registered ALU result.
- out_carry  output  1  registered ALU carry.
- out_zero  output  1  registered (alu_result == 0).
- out_sel  output  2  opcode that produced the result.
- occupancy  output  CNT_W  current FIFO entry count.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: wr_ptr, rd_ptr and count go to 0. out_valid, out_result, out_carry, out_zero and out_sel go to 0. in_ready goes to 1. alu_a, alu_b and alu_sel are 0 because the queue is empty.
- Reset mid-operation flushes all queued entries and any pending output. No partial transfer survives.
- Push: `push = in_valid && in_ready`. Writes {in_a, in_b, in_sel} at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Issue: `pop = (count != 0) && (!out_valid || out_ready)`.
  - On pop, the output regs capture alu_result, alu_carry, (alu_result == 0) and the head sel.
  - out_valid is set to 1; rd_ptr increments and wraps.
- Drain: `out_ready && out_valid && !pop` clears out_valid. Output data regs hold their last value.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: count == DEPTH, so in_ready = 0. A push is not accepted even if a pop occurs in the same cycle (no pass-through when full).
- Empty: count == 0, so no pop. A push into an empty queue is visible at the head on the next cycle.
- Latency: a request accepted at edge N drives the ALU during cycle N..N+1 and is captured at edge N+1. out_valid is high after edge N+1 (1-cycle minimum latency).
- Throughput: 1 result per cycle while out_ready is held at 1.
- Back-pressure: while out_valid = 1 and out_ready = 0, out_* are stable, no pop occurs, and the queue fills until in_ready = 0.
- Ordering: strictly FIFO, with no reordering or drops.
- ALU contract for `alu_4bit`:
  - 00 = a+b, carry = bit 4 of the sum.
  - 01 = a-b.
  - 10 = a&b.
  - 11 = a|b.
  - The block itself performs no arithmetic; out_zero is computed from alu_result only.
- in_* values while in_valid = 0 are ignored.
- occupancy equals count, updated at each edge.

Test Plan:
- Reset, then a single request a=3, b=2, sel=00 with out_ready=1: out_valid is high one cycle after acceptance with result=5, carry=0, zero=0, sel=00. occupancy then returns to 0.
- Back-to-back requests (4,1,01), (12,10,10), (12,10,11), (9,8,00) with out_ready=1: results appear in order on consecutive cycles.
  - Expected (result, carry): (3, –), (8, –), (14, –), (1, 1).
- out_ready held 0, then push 5 requests: the first is captured to the output; 4 fill the FIFO.
  - in_ready drops after the 5th accept and occupancy=4.
  - out_* stay stable while stalled.
  - Releasing out_ready drains all 5 in order.
- Zero flag: a=5, b=5, sel=01 gives result=0 and zero=1. a=0, b=0, sel=11 gives result=0 and zero=1.
- Full with out_ready=1 and in_valid=1: a pop occurs but the push is refused that cycle (in_ready=0). The push is accepted on the next cycle and occupancy never exceeds 4.
- Assert rst with 3 entries queued and out_valid=1: on the next edge out_valid=0, occupancy=0, in_ready=1 and alu_a/b/sel=0. A new request after reset produces a correct result and no stale entries are emitted.

Source files
------------

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_queue
// Purpose  : Flow-controlled front end for the combinational alu_4bit.
//            Requests {a, b, sel} are buffered in a DEPTH-entry FIFO. The
//            FIFO head drives the external ALU. The ALU result, carry, a
//            derived zero flag and the opcode are captured into a registered
//            output stage with its own valid/ready handshake.
// Ports    : clk, rst                   - clock, synchronous active-high reset
//            in_valid/in_ready          - request handshake (in_ready = !full)
//            in_a, in_b, in_sel         - request operands and opcode
//            alu_a, alu_b, alu_sel      - FIFO head to the ALU (0 when empty)
//            alu_result, alu_carry      - combinational ALU response
//            out_valid/out_ready        - result handshake
//            out_result, out_carry,
//            out_zero, out_sel          - registered result fields
//            occupancy                  - current FIFO entry count
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   input  logic [1:0]       in_sel,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [1:0]       alu_sel,
   input  logic [3:0]       alu_result,
   input  logic             alu_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_result,
   output logic             out_carry,
   output logic             out_zero,
   output logic [1:0]       out_sel,
   output logic [CNT_W-1:0] occupancy
);

   localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

   // Entry layout: {a[3:0], b[3:0], sel[1:0]}
   logic [9:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             r_out_valid;
   logic [3:0]       r_out_result;
   logic             r_out_carry;
   logic             r_out_zero;
   logic [1:0]       r_out_sel;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [9:0]       w_head;

   assign w_full   = (r_count == c_full);
   assign w_empty  = (r_count == '0);
   // No pass-through when full: a pop in the same cycle does not free a slot
   // for the push.
   assign in_ready = !w_full;
   assign w_push   = in_valid && in_ready;
   // Issue whenever the output stage is empty or is being drained this cycle.
   assign w_pop    = !w_empty && (!r_out_valid || out_ready);
   assign w_head   = r_mem[r_rd_ptr];

   assign alu_a    = w_empty ? 4'd0 : w_head[9:6];
   assign alu_b    = w_empty ? 4'd0 : w_head[5:2];
   assign alu_sel  = w_empty ? 2'd0 : w_head[1:0];

   // Storage needs no reset: entries are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_a, in_b, in_sel};
      end
   end

   // Pointers wrap naturally because DEPTH is 2**PTR_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Output stage: capture on issue; on a drain without a new issue only the
   // valid flag drops and the data fields keep their last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_result <= 4'd0;
         r_out_carry  <= 1'b0;
         r_out_zero   <= 1'b0;
         r_out_sel    <= 2'd0;
      end else if (w_pop) begin
         r_out_valid  <= 1'b1;
         r_out_result <= alu_result;
         r_out_carry  <= alu_carry;
         r_out_zero   <= (alu_result == 4'd0);
         r_out_sel    <= w_head[1:0];
      end else if (out_ready && r_out_valid) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_carry  = r_out_carry;
   assign out_zero   = r_out_zero;
   assign out_sel    = r_out_sel;
   assign occupancy  = r_count;

endmodule
`default_nettype wire
